// File: rtl/circuit_sq_acc_if.sv
// Sample/result bundle for the sum-of-squares accumulator.
// The master drives the enable and operand and observes the running sum.
interface circuit_sq_acc_if #(
  parameter int unsigned W = 96
);
  localparam int unsigned XW = 32;

  logic          en;
  logic [XW-1:0] x;
  logic [W-1:0]  y;

  modport master (output en, output x, input y);
  modport slave  (input en, input x, output y);
endinterface

// File: rtl/circuit_sq_acc.sv
// Three-stage pipelined sum-of-squares accumulator: capture, square, accumulate.
// The running sum wraps modulo 2^W and is presented straight from its register.
module circuit_sq_acc #(
  parameter int unsigned W = 96
) (
  input  logic             clk,
  input  logic             rst,
  circuit_sq_acc_if.slave  bus
);
  localparam int unsigned XW = 32;
  localparam int unsigned PW = 2 * XW;

  logic [XW-1:0] x_a;
  logic          v_a;
  logic [PW-1:0] p_b;
  logic          v_b;
  logic [W-1:0]  acc;

  // Stage A: operand capture; the operand holds while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_a <= '0;
      v_a <= 1'b0;
    end else begin
      v_a <= bus.en;
      if (bus.en) begin
        x_a <= bus.x;
      end
    end
  end

  // Stage B: full-precision unsigned square
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_b <= '0;
      v_b <= 1'b0;
    end else begin
      p_b <= PW'(x_a) * PW'(x_a);
      v_b <= v_a;
    end
  end

  // Stage C: accumulate valid squares, wrapping silently on overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (v_b) begin
      acc <= acc + W'(p_b);
    end
  end

  assign bus.y = acc;
endmodule

// File: tb/tb_circuit_sq_acc.sv
// Bench for circuit_sq_acc: W=96 and W=64 instances share stimulus and are
// compared every cycle against a sum-of-squares model with a two-edge lag.
module tb_circuit_sq_acc;
  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] x;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [95:0] m96;
  logic [63:0] m64;
  logic [63:0] pipe[$];

  circuit_sq_acc_if #(.W(96)) ifa ();
  circuit_sq_acc_if #(.W(64)) ifb ();

  assign ifa.en = en;
  assign ifa.x  = x;
  assign ifb.en = en;
  assign ifb.x  = x;

  circuit_sq_acc #(.W(96)) dut96 (.clk(clk), .rst(rst), .bus(ifa));
  circuit_sq_acc #(.W(64)) dut64 (.clk(clk), .rst(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk96(input string tag, input logic [95:0] exp);
    n_checks++;
    assert (ifa.y === exp) else begin
      n_fail++;
      $error("FAIL %s: y96 observed %h expected %h", tag, ifa.y, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] exp);
    n_checks++;
    assert (ifb.y === exp) else begin
      n_fail++;
      $error("FAIL %s: y64 observed %h expected %h", tag, ifb.y, exp);
    end
  endtask

  // Every enabled sample contributes x*x to the sum two edges after capture.
  task automatic tick(input string tag);
    logic        s_en;
    logic [31:0] s_x;
    logic        s_rst;
    logic [63:0] sq;
    s_en  = en;
    s_x   = x;
    s_rst = rst;
    @(posedge clk);
    #1;
    if (!s_rst) begin
      sq = s_en ? (64'(s_x) * 64'(s_x)) : 64'd0;
      pipe.push_back(sq);
      if (pipe.size() > 2) begin
        sq  = pipe.pop_front();
        m96 = m96 + 96'(sq);
        m64 = m64 + sq;
      end
    end
    chk96(tag, m96);
    chk64(tag, m64);
  endtask

  task automatic model_clear();
    pipe.delete();
    m96 = '0;
    m64 = '0;
  endtask

  // Synchronous-looking full reset: assert, hold two edges, release between edges.
  task automatic full_reset();
    rst = 1'b1;
    en  = 1'b0;
    #1;
    model_clear();
    tick("reset_hold");
    tick("reset_hold");
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    en  = 1'b0;
    x   = '0;
    model_clear();
    #1;
    chk96("reset_t0", 96'd0);
    chk64("reset_t0", 64'd0);

    // 1: single sample x=3
    full_reset();
    en = 1'b1; x = 32'd3;
    tick("single_e0");
    en = 1'b0;
    chk96("single_lat0", 96'd0);
    tick("single_e1");
    chk96("single_lat1", 96'd0);
    tick("single_e2");
    chk96("single_val", 96'd9);
    chk64("single_val", 64'd9);
    for (int i = 0; i < 3; i++) tick("single_hold");
    chk96("single_stay", 96'd9);

    // 2: back-to-back stream 1,2,3
    full_reset();
    en = 1'b1;
    x = 32'd1; tick("stream");
    x = 32'd2; tick("stream");
    x = 32'd3; tick("stream");
    chk96("stream_y1", 96'd1);
    en = 1'b0;
    tick("stream");
    chk96("stream_y5", 96'd5);
    tick("stream");
    chk96("stream_y14", 96'd14);
    tick("stream");
    chk96("stream_final", 96'd14);

    // 3/4: max operand, and wrap-around of the 64-bit instance
    full_reset();
    en = 1'b1; x = 32'hFFFF_FFFF;
    tick("max");
    tick("max");
    en = 1'b0;
    tick("max");
    chk96("max_one", 96'h0000_0000_FFFF_FFFE_0000_0001);
    chk64("max_one", 64'hFFFF_FFFE_0000_0001);
    tick("max");
    chk96("max_two", 96'h0000_0001_FFFF_FFFC_0000_0002);
    chk64("wrap_two", 64'hFFFF_FFFC_0000_0002);

    // 5: enable gating, then asynchronous reset with a sample in flight
    full_reset();
    en = 1'b1; x = 32'd10;
    tick("gate");
    en = 1'b0;
    tick("gate");
    tick("gate");
    chk96("gate_100", 96'd100);
    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      tick("gate_hold");
      chk96("gate_stay", 96'd100);
    end
    en = 1'b1; x = 32'd7;
    tick("inflight");
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk96("async_rst", 96'd0);
    chk64("async_rst", 64'd0);
    tick("rst_hold");
    rst = 1'b0;
    en = 1'b1; x = 32'd5;
    tick("post_rst");
    en = 1'b0;
    tick("post_rst");
    tick("post_rst");
    chk96("post_rst_25", 96'd25);
    tick("post_rst");
    chk96("post_rst_stay", 96'd25);

    // 6: random soak
    full_reset();
    for (int i = 0; i < 100; i++) begin
      en = 1'($urandom_range(0, 1));
      x  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      tick("soak");
    end
    en = 1'b0;
    tick("soak_drain");
    tick("soak_drain");
    tick("soak_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
